memory_unit: RTL and testbench

Byte-addressable, big-endian data memory with combinational read and synchronous, length-selectable write (byte / halfword / word). It serves as the core's unified instruction/data store. Unaligned accesses are fully supported. Read returns four consecutive bytes starting at `address`.

---
 rtl/memory_pkg.sv | 13 +
 rtl/memory_unit_if.sv | 26 ++
 rtl/memory_lane_decode.sv | 24 ++
 rtl/memory_unit.sv | 77 +++++++
 tb/tb_memory_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the memory unit: write-length encodings and byte-lane count.
package memory_pkg;

    typedef enum logic [1:0] {
        WL_BYTE = 2'd0,
        WL_HALF = 2'd1,
        WL_WORD = 2'd2,
        WL_RSVD = 2'd3
    } write_length_e;

    localparam int unsigned N_LANES = 4;

endpackage

// File: rtl/memory_unit_if.sv
// Access bus of the memory unit: address, write controls and combinational read data.
interface memory_unit_if;

    logic [31:0] address;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic [1:0]  write_length;
    logic [31:0] read_data;

    modport master (
        output address,
        output wr_data,
        output wr_enable,
        output write_length,
        input  read_data
    );

    modport slave (
        input  address,
        input  wr_data,
        input  wr_enable,
        input  write_length,
        output read_data
    );

endinterface

// File: rtl/memory_lane_decode.sv
// Byte-lane write-enable decode. Lane 0 is the byte at the access address and
// takes the most-significant byte of the write data.
module memory_lane_decode
    import memory_pkg::*;
(
    input  logic               i_wr_enable,
    input  logic [1:0]         i_write_length,
    output logic [N_LANES-1:0] o_lane_we
);

    // Select how many leading lanes a write touches; reserved length writes nothing.
    always_comb begin
        o_lane_we = '0;
        if (i_wr_enable) begin
            case (write_length_e'(i_write_length))
                WL_BYTE: o_lane_we = 4'b0001;
                WL_HALF: o_lane_we = 4'b0011;
                WL_WORD: o_lane_we = 4'b1111;
                WL_RSVD: o_lane_we = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/memory_unit.sv
// Byte-addressable big-endian memory: combinational 4-byte read, synchronous
// byte/halfword/word write, addresses wrap modulo DEPTH.
// Optional feature macro MEMORY_ALIGN_CHECK_EN adds the `misaligned` flag output.
module memory_unit
    import memory_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    memory_unit_if.slave  mem_bus
`ifdef MEMORY_ALIGN_CHECK_EN
    ,
    output logic          misaligned
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [AW-1:0]      w_idx [N_LANES];
    logic [N_LANES-1:0] w_lane_we;
    logic               w_unused_addr;

    // Address bits above the storage size only matter for the wrap, so they are dropped.
    assign w_unused_addr = ^mem_bus.address[31:AW];

    memory_lane_decode u_lane_decode (
        .i_wr_enable    (mem_bus.wr_enable),
        .i_write_length (mem_bus.write_length),
        .o_lane_we      (w_lane_we)
    );

    // Per-lane byte index; the AW-bit add wraps naturally at the top of memory.
    always_comb begin
        for (int k = 0; k < int'(N_LANES); k++) begin
            w_idx[k] = mem_bus.address[AW-1:0] + AW'(k);
        end
    end

    // Big-endian read assembly: lane 0 lands in the top byte.
    always_comb begin
        mem_bus.read_data = '0;
        for (int k = 0; k < int'(N_LANES); k++) begin
            mem_bus.read_data[31-8*k -: 8] = r_mem[w_idx[k]];
        end
    end

    // Storage update: reset clears everything and wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i[AW-1:0]] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < int'(N_LANES); k++) begin
                if (w_lane_we[k]) begin
                    r_mem[w_idx[k]] <= mem_bus.wr_data[31-8*k -: 8];
                end
            end
        end
    end

`ifdef MEMORY_ALIGN_CHECK_EN
    // Flag halfword/word writes off their natural boundary; the write still happens.
    always_comb begin
        misaligned = 1'b0;
        if (rst_n && mem_bus.wr_enable) begin
            if (mem_bus.write_length == WL_HALF && mem_bus.address[0] != 1'b0)
                misaligned = 1'b1;
            else if (mem_bus.write_length == WL_WORD && mem_bus.address[1:0] != 2'b00)
                misaligned = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: stimulus queues expected read values,
// a negedge monitor pops and compares them against read_data.
module tb_memory_unit;

    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst_n;
`ifdef MEMORY_ALIGN_CHECK_EN
    logic misaligned;
`endif

    memory_unit_if bus ();

    memory_unit #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_bus (bus)
`ifdef MEMORY_ALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q  [$];
    logic [31:0] mask_q [$];
    bit          neq_q  [$];
    string       name_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare one queued expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] m;
            bit          ne;
            string       nm;
            bit          ok;
            e  = exp_q.pop_front();
            m  = mask_q.pop_front();
            ne = neq_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (ne) ok = ((bus.read_data & m) != (e & m));
            else    ok = ((bus.read_data & m) == (e & m));
            if (!ok) begin
                n_errors++;
                $display("FAIL %s: read_data=%h required %s%h (mask %h)",
                         nm, bus.read_data, ne ? "not " : "", e, m);
            end
        end
    end

    task automatic push_chk(input string nm, input logic [31:0] e,
                            input logic [31:0] m, input bit ne);
        exp_q.push_back(e);
        mask_q.push_back(m);
        neq_q.push_back(ne);
        name_q.push_back(nm);
    endtask

    task automatic read_chk(input string nm, input logic [31:0] addr,
                            input logic [31:0] e, input logic [31:0] m);
        bus.address   = addr;
        bus.wr_enable = 1'b0;
        push_chk(nm, e, m, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] len);
        bus.address      = addr;
        bus.wr_data      = data;
        bus.write_length = len;
        bus.wr_enable    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $timeformat(-9, 0, " ns", 8);
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.address      = '0;
        bus.wr_data      = '0;
        bus.wr_enable    = 1'b0;
        bus.write_length = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        read_chk("reset_a0",   32'd0,         32'h0000_0000, 32'hFFFF_FFFF);
        read_chk("reset_a100", 32'd100,       32'h0000_0000, 32'hFFFF_FFFF);
        read_chk("reset_top",  32'(DEPTH-1),  32'h0000_0000, 32'hFFFF_FFFF);

        // Write inputs present but strobe low: nothing stored.
        bus.address      = 32'd0;
        bus.wr_data      = 32'h89AB_CDEF;
        bus.write_length = 2'd1;
        bus.wr_enable    = 1'b0;
        @(posedge clk);
        #1;
        read_chk("no_we", 32'd0, 32'h0000_0000, 32'hFFFF_FFFF);

        // Word write at 5: old contents visible until the committing edge.
        bus.address      = 32'd5;
        bus.wr_data      = 32'h1234_5678;
        bus.write_length = 2'd2;
        bus.wr_enable    = 1'b1;
        push_chk("pre_edge", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        read_chk("word_a5",   32'd5, 32'h1234_5678, 32'hFFFF_FFFF);
        read_chk("word_a4",   32'd4, 32'h0012_3456, 32'hFFFF_FFFF);
        read_chk("word_a8",   32'd8, 32'h7800_0000, 32'hFFFF_FFFF);

        // Back-to-back byte writes.
        do_write(32'd20, 32'h12AB_CDEF, 2'd0);
        do_write(32'd21, 32'h34FB_DEAD, 2'd0);
        do_write(32'd22, 32'h56ED_FABD, 2'd0);
        do_write(32'd23, 32'h78AD_EFAB, 2'd0);
        read_chk("bytes_a20", 32'd20, 32'h1234_5678, 32'hFFFF_FFFF);

        // Halfword writes at odd addresses.
        do_write(32'd37, 32'h1234_ABCD, 2'd1);
        do_write(32'd39, 32'h5678_EFDA, 2'd1);
        read_chk("half_a37", 32'd37, 32'h1234_5678, 32'hFFFF_FFFF);
        read_chk("half_a41", 32'd41, 32'h0000_0000, 32'hFFFF_FFFF);

        // Word write wrapping past the top of memory.
        do_write(32'(DEPTH-2), 32'hDEAD_BEEF, 2'd2);
        read_chk("wrap_top", 32'(DEPTH-2), 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        read_chk("wrap_a0",  32'd0,        32'hBEEF_0000, 32'hFFFF_0000);

        // Reset with a simultaneous write: reset wins and clears everything.
        bus.address      = 32'd8;
        bus.wr_data      = 32'hFFFF_FFFF;
        bus.write_length = 2'd2;
        bus.wr_enable    = 1'b1;
        rst_n            = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_chk("rst_wr_a8",  32'd8,        32'h0000_0000, 32'hFFFF_FFFF);
        read_chk("rst_a5",     32'd5,        32'h0000_0000, 32'hFFFF_FFFF);
        read_chk("rst_top",    32'(DEPTH-2), 32'h0000_0000, 32'hFFFF_FFFF);

        // Reserved length leaves contents unchanged.
        do_write(32'd8, 32'hCAFE_F00D, 2'd2);
        read_chk("word_a7",  32'd7, 32'h00CA_FEF0, 32'hFFFF_FFFF);
        do_write(32'd8, 32'hFFFF_FFFF, 2'd3);
        read_chk("rsvd_a8",  32'd8, 32'hCAFE_F00D, 32'hFFFF_FFFF);

`ifdef MEMORY_ALIGN_CHECK_EN
        bus.address      = 32'd37;
        bus.write_length = 2'd1;
        bus.wr_enable    = 1'b1;
        #1;
        n_checks++;
        if (misaligned !== 1'b1) begin
            n_errors++;
            $display("FAIL misaligned_half37: got %b required 1", misaligned);
        end
        bus.address      = 32'd40;
        bus.write_length = 2'd2;
        #1;
        n_checks++;
        if (misaligned !== 1'b0) begin
            n_errors++;
            $display("FAIL misaligned_word40: got %b required 0", misaligned);
        end
        bus.wr_enable = 1'b0;
        @(posedge clk);
        #1;
`endif

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
